// File: rtl/jpeg_enc_pkg.sv
// Shared definitions for the JPEG block encoder control path: the
// sequencer state encoding and the QUANT row-counter width.
package jpeg_enc_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      DCT_START,
      DCT_WAIT,
      DCT_END,
      QUANT,
      ZIGZAG,
      DC_CALC,
      HUFF_START,
      HUFF_WAIT
   } state_t;

   // Row counter spans 0 .. 7+QUANT_LAT, QUANT_LAT at most 7.
   localparam int ROW_W = 4;

endpackage

// File: rtl/jpeg_dc_predictor.sv
// Per-component DC predictor: keeps the last quantized DC of each colour
// component and produces the signed difference for the Huffman DC coder.
module jpeg_dc_predictor #(
   parameter int NUM_COMP = 3,
   parameter int DC_W     = 11
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            sample,
   input  logic            clear,
   input  logic [1:0]      comp_id,
   input  logic [DC_W-1:0] dc_coeff,
   output logic [DC_W:0]   dc_diff
);

   logic [DC_W-1:0] pred [NUM_COMP];
   logic [DC_W-1:0] pred_sel;

   // Select the predictor of the current component.
   always_comb begin
      pred_sel = '0;
      for (int i = 0; i < NUM_COMP; i++)
         if (comp_id == 2'(i)) pred_sel = pred[i];
   end

   // One extra bit on both operands makes the subtraction overflow-free.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_COMP; i++) pred[i] <= '0;
         dc_diff <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_COMP; i++) pred[i] <= '0;
      end else if (sample) begin
         dc_diff <= {dc_coeff[DC_W-1], dc_coeff} - {pred_sel[DC_W-1], pred_sel};
         for (int i = 0; i < NUM_COMP; i++)
            if (comp_id == 2'(i)) pred[i] <= dc_coeff;
      end
   end

endmodule

// File: rtl/jpeg_enc_sequencer.sv
// Block-level JPEG encode sequencer: accepts 8x8 blocks and drives every
// datapath strobe from load through Huffman start, cycling components.
// Outputs are registered from the next-state decode so each strobe lines
// up with the cycle its state occupies.
module jpeg_enc_sequencer
   import jpeg_enc_pkg::*;
#(
   parameter int NUM_COMP     = 3,
   parameter int DCT_LAT      = 4,
   parameter int QUANT_LAT    = 1,
   parameter int DC_W         = 11,
   parameter int HUFF_TIMEOUT = 1024
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            block_valid,
   input  logic            block_last,
   output logic            block_ready,
   output logic            load_enable,
   output logic            dct_enable,
   output logic            dct_end_enable,
   output logic [7:0]      matrix_row,
   output logic [7:0]      zz_row,
   output logic            zigzag_input_enable,
   output logic            zigzag_enable,
   output logic            huffman_start,
   input  logic            huffman_done,
   output logic            is_luminance,
   output logic [1:0]      comp_id,
   input  logic [DC_W-1:0] dc_coeff,
   output logic [DC_W:0]   dc_diff,
   output logic            dc_diff_valid,
   output logic            frame_done,
   output logic            error
);

   localparam int TO_W = $clog2(HUFF_TIMEOUT + 1);

   state_t           state, nxt;
   logic [7:0]       dcnt, dcnt_nxt;
   logic [ROW_W-1:0] row, row_nxt;
   logic [TO_W-1:0]  tcnt, tcnt_nxt;
   logic             last_q, accept, done_hit, timeout;
   logic [1:0]       comp_inc;

   assign comp_inc = (comp_id == 2'(NUM_COMP - 1)) ? 2'd0 : comp_id + 2'd1;

   jpeg_dc_predictor #(.NUM_COMP(NUM_COMP), .DC_W(DC_W)) u_pred (
      .clock    (clock),
      .reset    (reset),
      .sample   (state == DC_CALC),
      .clear    (done_hit && last_q),
      .comp_id  (comp_id),
      .dc_coeff (dc_coeff),
      .dc_diff  (dc_diff)
   );

   // Next-state, counter updates and handshake events.
   always_comb begin
      nxt      = state;
      dcnt_nxt = dcnt;
      row_nxt  = row;
      tcnt_nxt = tcnt;
      accept   = 1'b0;
      done_hit = 1'b0;
      timeout  = 1'b0;
      case (state)
         IDLE:
            if (block_valid && block_ready) begin
               accept = 1'b1;
               nxt    = LOAD;
            end
         LOAD:      nxt = DCT_START;
         DCT_START: begin
            dcnt_nxt = '0;
            nxt      = (DCT_LAT == 1) ? DCT_END : DCT_WAIT;
         end
         DCT_WAIT:
            if (dcnt == 8'(DCT_LAT - 2)) nxt = DCT_END;
            else                         dcnt_nxt = dcnt + 8'd1;
         DCT_END: begin
            row_nxt = '0;
            nxt     = QUANT;
         end
         QUANT:
            if (row == ROW_W'(7 + QUANT_LAT)) nxt = ZIGZAG;
            else                              row_nxt = row + 1'b1;
         ZIGZAG:     nxt = DC_CALC;
         DC_CALC:    nxt = HUFF_START;
         HUFF_START: begin
            tcnt_nxt = '0;
            nxt      = HUFF_WAIT;
         end
         HUFF_WAIT:
            if (huffman_done) begin
               done_hit = 1'b1;
               nxt      = IDLE;
            end else if (tcnt == TO_W'(HUFF_TIMEOUT - 1)) begin
               timeout = 1'b1;
               nxt     = IDLE;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         default: nxt = IDLE;
      endcase
   end

   // State and counter registers; latch the frame-last flag on accept.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         dcnt   <= '0;
         row    <= '0;
         tcnt   <= '0;
         last_q <= 1'b0;
      end else begin
         state <= nxt;
         dcnt  <= dcnt_nxt;
         row   <= row_nxt;
         tcnt  <= tcnt_nxt;
         if (accept) last_q <= block_last;
      end
   end

   // Registered outputs decoded from the upcoming state.
   always_ff @(posedge clock) begin
      if (reset) begin
         block_ready         <= 1'b0;
         load_enable         <= 1'b0;
         dct_enable          <= 1'b0;
         dct_end_enable      <= 1'b0;
         matrix_row          <= '0;
         zz_row              <= '0;
         zigzag_input_enable <= 1'b0;
         zigzag_enable       <= 1'b0;
         huffman_start       <= 1'b0;
         dc_diff_valid       <= 1'b0;
         frame_done          <= 1'b0;
         error               <= 1'b0;
         comp_id             <= 2'd0;
         is_luminance        <= 1'b1;
      end else begin
         block_ready         <= (nxt == IDLE);
         load_enable         <= (nxt == LOAD);
         dct_enable          <= (nxt == DCT_START);
         dct_end_enable      <= (nxt == DCT_END);
         zigzag_enable       <= (nxt == ZIGZAG);
         huffman_start       <= (nxt == HUFF_START);
         dc_diff_valid       <= (nxt == HUFF_START);
         frame_done          <= done_hit && last_q;
         matrix_row          <= '0;
         zz_row              <= '0;
         zigzag_input_enable <= 1'b0;
         if (nxt == QUANT) begin
            matrix_row <= (row_nxt > ROW_W'(7)) ? 8'd7 : 8'(row_nxt);
            if (row_nxt >= ROW_W'(QUANT_LAT)) begin
               zigzag_input_enable <= 1'b1;
               zz_row              <= 8'(row_nxt - ROW_W'(QUANT_LAT));
            end
         end
         if (timeout) error <= 1'b1;
         if (done_hit) begin
            comp_id      <= last_q ? 2'd0 : comp_inc;
            is_luminance <= last_q || (comp_inc == 2'd0);
         end
      end
   end

endmodule

// File: tb/tb_jpeg_enc_sequencer.sv
// Directed bench for jpeg_enc_sequencer (NUM_COMP=3, default latencies):
// a table of blocks with hand-computed DC differences and component ids,
// each checked cycle by cycle against the strobe schedule, plus a
// reset-in-QUANT sequence.
module tb_jpeg_enc_sequencer;

   localparam int D  = 4;
   localparam int Q  = 1;
   localparam int TO = 1024;

   logic        clock = 1'b0;
   logic        reset, block_valid, block_last, huffman_done;
   logic        block_ready, load_enable, dct_enable, dct_end_enable;
   logic [7:0]  matrix_row, zz_row;
   logic        zigzag_input_enable, zigzag_enable, huffman_start;
   logic        is_luminance, dc_diff_valid, frame_done, error;
   logic [1:0]  comp_id;
   logic [10:0] dc_coeff;
   logic [11:0] dc_diff;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   jpeg_enc_sequencer #(.NUM_COMP(3)) dut (
      .clock(clock), .reset(reset), .block_valid(block_valid), .block_last(block_last),
      .block_ready(block_ready), .load_enable(load_enable), .dct_enable(dct_enable),
      .dct_end_enable(dct_end_enable), .matrix_row(matrix_row), .zz_row(zz_row),
      .zigzag_input_enable(zigzag_input_enable), .zigzag_enable(zigzag_enable),
      .huffman_start(huffman_start), .huffman_done(huffman_done),
      .is_luminance(is_luminance), .comp_id(comp_id), .dc_coeff(dc_coeff),
      .dc_diff(dc_diff), .dc_diff_valid(dc_diff_valid), .frame_done(frame_done),
      .error(error)
   );

   typedef struct {
      int dc;     // dc_coeff presented
      bit last;   // block_last
      int dly;    // huffman_done seen in cycle 18+dly; negative = never
      int comp;   // expected comp_id
      bit lum;    // expected is_luminance
      int diff;   // expected dc_diff
      bit err_in; // error level during the block
      bit err_out;// error level once back in IDLE
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Strobe word: {ready,load,dct,dct_end,zie,zz_en,hstart,dcv,fdone,err}
   function automatic logic [9:0] strobes();
      return {block_ready, load_enable, dct_enable, dct_end_enable, zigzag_input_enable,
              zigzag_enable, huffman_start, dc_diff_valid, frame_done, error};
   endfunction

   // Expected strobes/rows for cycle c after the accept edge.
   task automatic expect_cycle(input int c, input bit err, output logic [9:0] s,
                               output logic [15:0] rows, output bit inq, output bit inz);
      int r;
      r    = c - (3 + D);
      inq  = (c >= 3 + D) && (c <= 10 + D + Q);
      inz  = inq && (r >= Q);
      s    = {1'b0, c == 1, c == 2, c == 2 + D, inz, c == 11 + D + Q,
              c == 13 + D + Q, c == 13 + D + Q, 1'b0, err};
      rows = {inq ? 8'((r > 7) ? 7 : r) : 8'h0, inz ? 8'(r - Q) : 8'h0};
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (block_ready !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (block_ready !== 1'b1) begin
         errors++;
         checks++;
         $display("FAIL %s: block_ready timeout got %b want 1", name, block_ready);
      end
   endtask

   task automatic run_block(input int idx, input vec_t v);
      logic [9:0]  es;
      logic [15:0] er;
      bit          inq, inz;
      int          last_c;
      string       nm;
      last_c = (v.dly >= 0) ? 13 + D + Q + v.dly : 13 + D + Q + TO;
      dc_coeff    = 11'(v.dc);
      block_last  = v.last;
      block_valid = 1'b1;
      wait_ready($sformatf("blk%0d", idx));
      @(posedge clock);
      for (int c = 1; c <= last_c; c++) begin
         @(negedge clock);
         block_valid = 1'b0;
         expect_cycle(c, v.err_in, es, er, inq, inz);
         nm = $sformatf("blk%0d cyc%0d", idx, c);
         chk(nm, {38'h0, strobes(), inq ? matrix_row : 8'h0, inz ? zz_row : 8'h0},
             {38'h0, es, er});
         if (c == 13 + D + Q)
            chk({nm, " dc"}, {49'h0, comp_id, is_luminance, dc_diff},
                {49'h0, 2'(v.comp), v.lum, 12'(v.diff)});
         huffman_done = (v.dly >= 0) && (c == last_c);
      end
      @(negedge clock);
      huffman_done = 1'b0;
      chk($sformatf("blk%0d end", idx), {61'h0, block_ready, frame_done, error},
          {61'h0, 1'b1, v.last && (v.dly >= 0), v.err_out});
   endtask

   initial begin
      tbl[0]  = '{100,   0, 5,  0, 1, 100,   0, 0};
      tbl[1]  = '{-1024, 0, 1,  1, 0, -1024, 0, 0};
      tbl[2]  = '{7,     0, 2,  2, 0, 7,     0, 0};
      tbl[3]  = '{90,    0, 3,  0, 1, -10,   0, 0};
      tbl[4]  = '{1023,  0, 1,  1, 0, 2047,  0, 0};
      tbl[5]  = '{7,     0, 1,  2, 0, 0,     0, 0};
      tbl[6]  = '{-1024, 0, 4,  0, 1, -1114, 0, 0};
      tbl[7]  = '{5,     1, 2,  1, 0, -1018, 0, 0};
      tbl[8]  = '{50,    0, 1,  0, 1, 50,    0, 0};
      tbl[9]  = '{3,     0, 1,  1, 0, 3,     0, 0};
      tbl[10] = '{-2,    0, 1,  2, 0, -2,    0, 0};
      tbl[11] = '{60,    0, 2,  0, 1, 10,    0, 0};
      tbl[12] = '{20,    0, -1, 1, 0, 17,    0, 1};
      tbl[13] = '{25,    0, 1,  1, 0, 5,     1, 1};

      reset = 1'b1; block_valid = 1'b0; block_last = 1'b0;
      huffman_done = 1'b0; dc_coeff = '0;
      repeat (2) @(negedge clock);
      chk("reset state", {38'h0, strobes(), matrix_row, zz_row},  {38'h0, 26'h0});
      chk("reset comp/dc", {49'h0, comp_id, is_luminance, dc_diff}, {49'h0, 2'd0, 1'b1, 12'h0});
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("ready after reset", {63'h0, block_ready}, {63'h0, 1'b1});

      for (int i = 0; i < 14; i++) run_block(i, tbl[i]);

      // Reset during QUANT row 3 of a comp-2 block.
      dc_coeff = 11'd400; block_last = 1'b0; block_valid = 1'b1;
      wait_ready("rst blk");
      @(posedge clock);
      for (int c = 1; c <= 3 + D + 3; c++) begin
         @(negedge clock);
         block_valid = 1'b0;
      end
      chk("row3 before reset", {56'h0, matrix_row}, {56'h0, 8'd3});
      reset = 1'b1;
      @(negedge clock);
      chk("strobes after reset", {38'h0, strobes(), matrix_row, zz_row}, {38'h0, 26'h0});
      chk("comp after reset", {61'h0, comp_id, is_luminance}, {61'h0, 2'd0, 1'b1});
      reset = 1'b0;
      @(negedge clock);
      run_block(99, '{-300, 0, 2, 0, 1, -300, 0, 0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
